aes_round_ctrl: RTL
===================

# aes_round_ctrl

Round sequencer for the iterative AES-128 encryption datapath. It accepts one block per handshake and steps the shared round hardware through the initial AddRoundKey and NR rounds: the registered subBytes stage, then ShiftRows/MixColumns/AddRoundKey. It also drives key-expansion strobes and round constants, then presents the result through a valid/ready output handshake. It holds no data; it only produces control signals for the datapath's state and key registers.

## Interface
- NR, default 10: number of rounds. Only 10 is supported; the RCON table is sized for it.
- SB_LAT, default 1: register latency of the subBytes stage in cycles. Must be ≥1.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a plaintext block and key are present on the datapath inputs.
- in_ready  out  1  the controller can accept a block. Reset value 1.
- out_valid  out  1  the datapath state register holds the ciphertext. Reset value 0.
- out_ready  in  1  the consumer takes the ciphertext.
- state_ld  out  1  load enable for the datapath state register. Reset value 0.
- state_sel  out  1  state register source: 0 = input XOR key0 (INIT), 1 = round result. Reset value 0.
- key_load  out  1  load the cipher key into the round-key register. Reset value 0.
- key_step  out  1  advance key expansion by one round using rcon. Reset value 0.
- rcon  out  8  round constant for the current key step. Reset value 8'h00.
- mix_bypass  out  1  skip MixColumns (final round only). Reset value 0.
- round  out  4  current round index, 0..NR. Reset value 0.
- busy  out  1  a block is in flight (any state except IDLE). Reset value 0.

## Operation
- FSM states: IDLE, SUB, RK, DONE.
- IDLE: in_ready=1.
  - On in_valid: assert state_ld=1, state_sel=0, key_load=1; set round←1; go to SUB.
- SUB: lasts SB_LAT cycles, counted by sub_cnt.
  - key_step=1 in the first SUB cycle of each round only.
  - rcon = RCON[round]: 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.
  - After the last SUB cycle, go to RK.
- RK: one cycle. Assert state_ld=1, state_sel=1, mix_bypass=(round==NR).
  - If round==NR, go to DONE; otherwise round←round+1 and go to SUB.
- DONE: out_valid=1; round holds NR.
  - If out_ready and in_valid: back-to-back accept. in_ready=1; perform the IDLE accept actions in the same cycle; go to SUB with round=1.
  - If out_ready without in_valid: go to IDLE; round←0.
  - Otherwise hold; out_valid stays 1 and the state register is not loaded.
- in_ready = (IDLE) or (DONE and out_ready). It is low in SUB and RK; in_valid is ignored there.
- The round counter is 4-bit and never exceeds NR; there is no wrap-around path.
- Outside the listed conditions, state_ld, key_load, key_step and mix_bypass are 0, and rcon is 8'h00.
- rst in any state, including mid-round: next cycle is IDLE with all outputs at their reset values. The in-flight block is discarded.

## Timing
- Accept at cycle T: out_valid rises at T + 1 + NR*(SB_LAT+1). With defaults this is T+21.
- Throughput: one block per 1 + NR*(SB_LAT+1) cycles when back-to-back in DONE. There is no idle bubble.
- All outputs are registered or decoded from registered state only. There is no combinational in_valid→out or out_ready→out path, except in_ready in DONE, which depends combinationally on out_ready.

## Structure
- Package aes_pkg holds:
  - the state enum type;
  - the RCON constant array indexed 1..10;
  - the xtime function;
  - localparam NR_AES128=10.
- No sub-module. The FSM, sub_cnt and round counter fit in a single module.
- The datapath (subBytes, shiftRows, mixColumns, key expansion) is instantiated beside this block, not inside it.

## Test plan
- Single block: FIPS-197 key 000102..0f, plaintext 00112233..ff. out_valid at T+21; ciphertext 69c4e0d8..c55a. rcon sequence 01..36 observed on key_step cycles.
- Back-to-back: in_valid and out_ready held high. Second accept occurs in the DONE cycle; the two out_valid pulses are exactly 21 cycles apart.
- Backpressure: out_ready low for 5 cycles in DONE. out_valid stays 1, in_ready stays 0, state_ld stays 0, and the ciphertext is unchanged.
- Reset mid-operation: rst asserted in round 5 RK. Next cycle is IDLE with in_ready=1, round=0 and all strobes 0. A new block then completes correctly.
- SB_LAT=2 build: latency is 31 cycles; key_step asserts once per round; mix_bypass asserts only in round-10 RK.
- in_valid pulsed during SUB/RK: ignored; no second key_load occurs.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 round controller.
package aes_pkg;

  localparam int unsigned NR_AES128 = 10;

  // Controller FSM states.
  typedef enum logic [1:0] {
    StIdle,
    StSub,
    StRk,
    StDone
  } aes_ctrl_state_e;

  // Round constants for key expansion, indexed by round number 1..10.
  localparam logic [7:0] RCON [1:NR_AES128] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round constant for a round index; zero outside 1..10.
  function automatic logic [7:0] rcon_lookup(input logic [3:0] r);
    if (r >= 4'd1 && r <= 4'(NR_AES128)) begin
      return RCON[r];
    end
    return 8'h00;
  endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// Round sequencer for an iterative AES-128 datapath. Produces load/step strobes, the round
// constant and the round index; carries no data itself.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR     = NR_AES128,
  parameter int unsigned SB_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       state_ld,
  output logic       state_sel,
  output logic       key_load,
  output logic       key_step,
  output logic [7:0] rcon,
  output logic       mix_bypass,
  output logic [3:0] round,
  output logic       busy
);

  localparam int unsigned     SubW      = (SB_LAT > 1) ? $clog2(SB_LAT) : 1;
  localparam logic [SubW-1:0] SubLast   = SubW'(SB_LAT - 1);
  localparam logic [3:0]      RoundLast = 4'(NR);

  aes_ctrl_state_e state_q;
  logic [SubW-1:0] sub_cnt_q;
  logic            accept;

  // Only path from an input to an output: a waiting consumer frees the controller in DONE.
  assign in_ready = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept   = in_ready && in_valid;

  // FSM with registered strobes; each strobe is high for exactly the cycle it is set for.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sub_cnt_q  <= '0;
      out_valid  <= 1'b0;
      state_ld   <= 1'b0;
      state_sel  <= 1'b0;
      key_load   <= 1'b0;
      key_step   <= 1'b0;
      rcon       <= 8'h00;
      mix_bypass <= 1'b0;
      round      <= 4'd0;
      busy       <= 1'b0;
    end else begin
      state_ld   <= 1'b0;
      state_sel  <= 1'b0;
      key_load   <= 1'b0;
      key_step   <= 1'b0;
      rcon       <= 8'h00;
      mix_bypass <= 1'b0;
      if (accept) begin
        // Load input^key0 and the cipher key; the first SUB cycle also steps to key1, so the
        // datapath expands straight from the input key when key_load and key_step coincide.
        state_q   <= StSub;
        sub_cnt_q <= '0;
        round     <= 4'd1;
        state_ld  <= 1'b1;
        key_load  <= 1'b1;
        key_step  <= 1'b1;
        rcon      <= rcon_lookup(4'd1);
        out_valid <= 1'b0;
        busy      <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            // nothing to do until a block is offered
          end
          StSub: begin
            if (sub_cnt_q == SubLast) begin
              state_q    <= StRk;
              state_ld   <= 1'b1;
              state_sel  <= 1'b1;
              mix_bypass <= (round == RoundLast);
            end else begin
              sub_cnt_q <= sub_cnt_q + 1'b1;
              rcon      <= rcon_lookup(round);
            end
          end
          StRk: begin
            if (round == RoundLast) begin
              state_q   <= StDone;
              out_valid <= 1'b1;
            end else begin
              state_q   <= StSub;
              sub_cnt_q <= '0;
              round     <= round + 4'd1;
              key_step  <= 1'b1;
              rcon      <= rcon_lookup(round + 4'd1);
            end
          end
          StDone: begin
            if (out_ready) begin
              state_q   <= StIdle;
              out_valid <= 1'b0;
              round     <= 4'd0;
              busy      <= 1'b0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
